// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
// Holds the queue entry layout, the reset PC, the NOP encoding and the queue depth.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_8000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam int          FETCH_QDEPTH     = 2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of {instr, pc} between instruction memory and decode.
// Enqueue and dequeue may happen together at any occupancy; flush empties it.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = FETCH_QDEPTH,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enq,
    input  fetch_entry_t  enq_data,
    input  logic          deq,
    input  logic          flush,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);

    fetch_entry_t mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          wr_en;
    logic          rd_en;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign wr_en = enq && !flush;
    assign rd_en = deq && (count != '0) && !flush;
    assign head  = mem[rd_ptr];

    // When full, a same-cycle dequeue frees the slot the write lands in.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= enq_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + {{(CW-1){1'b0}}, wr_en} - {{(CW-1){1'b0}}, rd_en};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues 1-cycle-latency imem reads,
// buffers responses in fetch_queue and handles redirect flushes and halt.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = FETCH_QDEPTH
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic          halted;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  enq_data;
    logic          deq;
    logic          flush;
    logic          enq;
    logic          issue;
    logic [CW:0]   occupancy;

    assign ir_valid  = (count != '0);
    assign deq       = ir_valid && ir_ready;
    assign flush     = redirect || halt;
    assign enq       = inflight && !flush;
    assign enq_data  = '{instr: imem_rdata, pc: inflight_pc};

    // Slots committed after this cycle; an in-flight word already owns one.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, deq};
    assign issue     = !rst && !halted && !flush && (occupancy < (CW+1)'(DEPTH));

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;
    assign ir        = ir_valid ? head.instr : NOP_INSTR;
    assign ir_pc     = ir_valid ? head.pc : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
            halted      <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 32'd4;
            end
            if (halt) begin
                halted <= 1'b1;
            end else if (redirect) begin
                fetch_pc <= align_pc(redirect_pc);
            end
        end
    end

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .enq      (enq),
        .enq_data (enq_data),
        .deq      (deq),
        .flush    (flush),
        .count    (count),
        .head     (head)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a PC-indexed memory model feeds the DUT and
// every accepted instruction is checked against a queue of expected PCs.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [31:0] exp_q [$];

    logic        last_req;
    logic [31:0] last_addr;
    logic        last_valid;
    logic [31:0] last_ir;
    logic [31:0] last_pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (32'h0000_8000),
        .DEPTH    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory: word is valid the cycle after the request.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? word_at(imem_addr) : 32'hBAD0_BAD0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sample mid-cycle, score any handshake, then advance to just after the edge.
    task automatic step();
        logic [31:0] e;
        @(negedge clk);
        last_req   = imem_req;
        last_addr  = imem_addr;
        last_valid = ir_valid;
        last_ir    = ir;
        last_pc    = ir_pc;
        if (ir_valid && ir_ready) begin
            check("sb_nonempty", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("ir_pc", ir_pc, e);
                check("ir", ir, word_at(e));
                $display("deq pc=%h ir=%h", ir_pc, ir);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #3;
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        halt        = 1'b0;
        ir_ready    = 1'b0;

        step();
        step();
        check("rst_req",   {31'b0, last_req},   32'd0);
        check("rst_addr",  last_addr,           32'h0000_8000);
        check("rst_valid", {31'b0, last_valid}, 32'd0);
        check("rst_ir",    last_ir,             32'h0000_0013);
        check("rst_ir_pc", last_pc,             32'h0);

        // Streaming from reset: one instruction per cycle from E2.
        rst = 1'b0;
        ir_ready = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h8000 + 32'(4 * i));
        step();
        check("e0_req",   {31'b0, last_req},   32'd1);
        check("e0_addr",  last_addr,           32'h0000_8000);
        check("e0_valid", {31'b0, last_valid}, 32'd0);
        step();
        check("e1_valid", {31'b0, last_valid}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            check("stream_valid", {31'b0, last_valid}, 32'd1);
        end

        // Backpressure: queue fills with 0x8020/0x8024 and fetch stalls.
        ir_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_req",   {31'b0, last_req}, 32'd0);
            check("bp_ir_pc", last_pc,           32'h0000_8020);
        end
        check("bp_addr", last_addr, 32'h0000_8028);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h8020 + 32'(4 * i));
        ir_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_release_valid", {31'b0, last_valid}, 32'd1);
        end

        // Fill again, accept one so a request is in flight, then redirect.
        ir_ready = 1'b0;
        for (int i = 0; i < 6; i++) step();
        exp_q.push_back(32'h8030);
        ir_ready = 1'b1;
        step();
        ir_ready    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_8102;
        step();
        check("redir_req", {31'b0, last_req}, 32'd0);
        redirect = 1'b0;
        ir_ready = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h8100 + 32'(4 * i));
        step();
        check("redir_t1_req",   {31'b0, last_req},   32'd1);
        check("redir_t1_addr",  last_addr,           32'h0000_8100);
        check("redir_t1_valid", {31'b0, last_valid}, 32'd0);
        step();
        check("redir_t2_valid", {31'b0, last_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("redir_valid", {31'b0, last_valid}, 32'd1);
        end
        check("redir_sb_drained", 32'(exp_q.size()), 32'd0);

        // Redirect to the top word: PC wraps to zero.
        ir_ready    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        ir_ready = 1'b1;
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        step();
        check("wrap_addr", last_addr, 32'hFFFF_FFFC);
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            check("wrap_valid", {31'b0, last_valid}, 32'd1);
        end

        // Halt together with redirect: halt wins and fetch stays dead.
        ir_ready    = 1'b0;
        halt        = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_9000;
        step();
        check("halt_req", {31'b0, last_req}, 32'd0);
        halt     = 1'b0;
        redirect = 1'b0;
        ir_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("halted_req",   {31'b0, last_req},   32'd0);
            check("halted_valid", {31'b0, last_valid}, 32'd0);
        end
        check("halt_sb_drained", 32'(exp_q.size()), 32'd0);

        // Short reset pulse recovers from halt.
        pulse_rst();
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h8000 + 32'(4 * i));
        step();
        check("recover_req",  {31'b0, last_req}, 32'd1);
        check("recover_addr", last_addr,         32'h0000_8000);
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            check("recover_valid", {31'b0, last_valid}, 32'd1);
        end

        // Short reset pulse while a request is in flight: stale word dropped.
        pulse_rst();
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h8000 + 32'(4 * i));
        step();
        check("inflight_rst_valid0", {31'b0, last_valid}, 32'd0);
        check("inflight_rst_addr",   last_addr,           32'h0000_8000);
        step();
        check("inflight_rst_valid1", {31'b0, last_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("restart_valid", {31'b0, last_valid}, 32'd1);
        end
        ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("final_sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
